// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter with programmable wait states and ROM write protection.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module mem_bus_arbiter #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [15:0] ROM_LIMIT   = 16'h0100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [15:0] p0_addr,
  input  logic [7:0]  p0_wdata,
  output logic        p0_ack,
  output logic [7:0]  p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [15:0] p1_addr,
  input  logic [7:0]  p1_wdata,
  output logic        p1_ack,
  output logic [7:0]  p1_rdata,
  output logic        p1_err,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [2:0]  waitCnt_q, waitCnt_d;
  logic        errPend_q, errPend_d;
  logic [7:0]  rdata0_q, rdata0_d;
  logic [7:0]  rdata1_q, rdata1_d;
  logic        pick;

  // grant_q doubles as the last-grant pointer for round-robin tie breaking
`ifdef ARB_ROUND_ROBIN_EN
  assign pick = (p0_req && p1_req) ? ~grant_q : ~p0_req;
`else
  assign pick = ~p0_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      waitCnt_q <= '0;
      errPend_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      waitCnt_q <= waitCnt_d;
      errPend_q <= errPend_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    waitCnt_d = waitCnt_q;
    errPend_d = errPend_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          grant_d   = pick;
          we_d      = pick ? p1_we    : p0_we;
          addr_d    = pick ? p1_addr  : p0_addr;
          wdata_d   = pick ? p1_wdata : p0_wdata;
          waitCnt_d = WAIT_INIT;
          errPend_d = we_d && (addr_d < ROM_LIMIT);
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (waitCnt_q == 3'd0) begin
          state_d = DONE;
          if (!we_q) begin
            if (grant_q) rdata1_d = mem_rdata;
            else         rdata0_d = mem_rdata;
          end
        end else begin
          waitCnt_d = waitCnt_q - 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A rejected ROM write still runs its wait states, just without a strobe
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_read  = (state_q == ACCESS) && !we_q;
    mem_write = (state_q == ACCESS) && we_q && !errPend_q;
    busy      = (state_q != IDLE);
    owner     = grant_q;
    p0_ack    = (state_q == DONE) && !grant_q;
    p1_ack    = (state_q == DONE) && grant_q;
    p0_err    = p0_ack && errPend_q;
    p1_err    = p1_ack && errPend_q;
    p0_rdata  = rdata0_q;
    p1_rdata  = rdata1_q;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard testbench for mem_bus_arbiter: one instance with WAIT_STATES=1, one with 0.
// Honours ARB_ROUND_ROBIN_EN the same way as the design when predicting contention grants.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        p0Req, p0We, p1Req, p1We;
  logic [15:0] p0Addr, p1Addr;
  logic [7:0]  p0Wdata, p1Wdata;
  logic        p0Ack, p1Ack, p0Err, p1Err;
  logic [7:0]  p0Rdata, p1Rdata;
  logic [15:0] memAddr;
  logic [7:0]  memWdata, memRdata;
  logic        memRead, memWrite, busy, owner;

  logic        zP0Req;
  logic [15:0] zP0Addr;
  logic        zP0Ack, zP1Ack, zP0Err, zP1Err;
  logic [7:0]  zP0Rdata, zP1Rdata;
  logic [15:0] zMemAddr;
  logic [7:0]  zMemWdata, zMemRdata;
  logic        zMemRead, zMemWrite, zBusy, zOwner;

  mem_bus_arbiter #(.WAIT_STATES(1), .ROM_LIMIT(16'h0100)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0Req), .p0_we(p0We), .p0_addr(p0Addr), .p0_wdata(p0Wdata),
    .p0_ack(p0Ack), .p0_rdata(p0Rdata), .p0_err(p0Err),
    .p1_req(p1Req), .p1_we(p1We), .p1_addr(p1Addr), .p1_wdata(p1Wdata),
    .p1_ack(p1Ack), .p1_rdata(p1Rdata), .p1_err(p1Err),
    .mem_addr(memAddr), .mem_wdata(memWdata), .mem_rdata(memRdata),
    .mem_read(memRead), .mem_write(memWrite), .busy(busy), .owner(owner)
  );

  mem_bus_arbiter #(.WAIT_STATES(0), .ROM_LIMIT(16'h0100)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .p0_req(zP0Req), .p0_we(1'b0), .p0_addr(zP0Addr), .p0_wdata(8'h00),
    .p0_ack(zP0Ack), .p0_rdata(zP0Rdata), .p0_err(zP0Err),
    .p1_req(1'b0), .p1_we(1'b0), .p1_addr(16'h0000), .p1_wdata(8'h00),
    .p1_ack(zP1Ack), .p1_rdata(zP1Rdata), .p1_err(zP1Err),
    .mem_addr(zMemAddr), .mem_wdata(zMemWdata), .mem_rdata(zMemRdata),
    .mem_read(zMemRead), .mem_write(zMemWrite), .busy(zBusy), .owner(zOwner)
  );

  // Memory model: ROM preloaded by the bench, RAM written only through mem_write
  logic [7:0] rom [256];
  logic [7:0] ram [65536];
  logic       romWriteSeen;

  assign memRdata  = (memAddr  < 16'h0100) ? rom[memAddr[7:0]]  : ram[memAddr];
  assign zMemRdata = (zMemAddr < 16'h0100) ? rom[zMemAddr[7:0]] : ram[zMemAddr];

  always @(posedge clk) begin
    if (!reset_n) romWriteSeen <= 1'b0;
    else if (memWrite) begin
      ram[memAddr] <= memWdata;
      if (memAddr < 16'h0100) romWriteSeen <= 1'b1;
    end
  end

  typedef struct {
    logic       port;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t        sbQ[$];
  logic [7:0]  heldRdata [2];
  logic        modelLast;
  logic        curPort;
  logic [15:0] curAddr;
  logic [7:0]  curWdata;
  int          nChecks = 0;
  int          nFail = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic port, input logic we, input logic [15:0] addr,
                               input logic [7:0] wdata, input logic [7:0] expRd);
    exp_t e;
    curPort  = port;
    curAddr  = addr;
    curWdata = wdata;
    if (!we) heldRdata[port] = expRd;
    e.port  = port;
    e.rdata = heldRdata[port];
    e.err   = we && (addr < 16'h0100);
    sbQ.push_back(e);
    modelLast = port;
    if (port) begin
      p1Req = 1'b1; p1We = we; p1Addr = addr; p1Wdata = wdata;
    end else begin
      p0Req = 1'b1; p0We = we; p0Addr = addr; p0Wdata = wdata;
    end
  endtask

  task automatic popCompare(input string tag);
    exp_t e;
    logic ackPort;
    if (sbQ.size() == 0) begin
      checkOutput({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = sbQ.pop_front();
      ackPort = p1Ack;
      checkOutput({tag, " ack port"}, ackPort, e.port);
      checkOutput({tag, " rdata"}, ackPort ? p1Rdata : p0Rdata, e.rdata);
      checkOutput({tag, " err"}, ackPort ? p1Err : p0Err, e.err);
      checkOutput({tag, " other ack"}, ackPort ? p0Ack : p1Ack, 1'b0);
    end
  endtask

  // Runs one WAIT_STATES=1 access to completion and checks strobes and latency
  task automatic waitAck(input string tag, input int expReads, input int expWrites);
    int  reads = 0;
    int  writes = 0;
    int  lat = 0;
    logic got = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (memRead)  reads++;
      if (memWrite) writes++;
      if (memRead || memWrite) checkOutput({tag, " mem_addr"}, memAddr, curAddr);
      if (memWrite) checkOutput({tag, " mem_wdata"}, memWdata, curWdata);
      if (p0Ack || p1Ack) begin
        lat = i;
        got = 1'b1;
        break;
      end
    end
    checkOutput({tag, " ack seen"}, got, 1'b1);
    if (got) begin
      popCompare(tag);
      checkOutput({tag, " latency"}, lat, 3);
      checkOutput({tag, " read strobes"}, reads, expReads);
      checkOutput({tag, " write strobes"}, writes, expWrites);
      checkOutput({tag, " owner"}, owner, curPort);
    end
    p0Req = 1'b0;
    p1Req = 1'b0;
  endtask

  initial begin
    logic ackSeen;
    logic got;
    int   zStrobes;
    int   zAcks;
    int   zLastAck;
    exp_t e;

    for (int i = 0; i < 256; i++) rom[i] = 8'(i);
    rom[4]  = 8'h0A;
    rom[16] = 8'h33;
    heldRdata[0] = 8'h00;
    heldRdata[1] = 8'h00;
    modelLast = 1'b1;
    curPort = 1'b0; curAddr = '0; curWdata = '0;
    p0Req = 0; p0We = 0; p0Addr = '0; p0Wdata = '0;
    p1Req = 0; p1We = 0; p1Addr = '0; p1Wdata = '0;
    zP0Req = 0; zP0Addr = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset mem_read", memRead, 1'b0);
    checkOutput("reset mem_write", memWrite, 1'b0);
    checkOutput("reset acks", {p0Ack, p1Ack}, 2'b00);
    checkOutput("reset errs", {p0Err, p1Err}, 2'b00);
    checkOutput("reset mem_addr", memAddr, 16'h0000);
    checkOutput("reset mem_wdata", memWdata, 8'h00);
    checkOutput("reset rdata", {p0Rdata, p1Rdata}, 16'h0000);
    checkOutput("reset owner", owner, 1'b1);
    checkOutput("reset z busy/strobes", {zBusy, zMemRead, zMemWrite}, 3'b000);
    checkOutput("reset z owner", zOwner, 1'b1);
    checkOutput("reset z outputs", {zP1Rdata, zMemWdata, zP0Err, zP1Err, zP0Ack, zP1Ack}, 20'h0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] single read, RAM write/readback, ROM write");
    applyStimulus(1'b0, 1'b0, 16'h0004, 8'h00, 8'h0A);
    waitAck("p0 read rom", 2, 0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 16'h0200, 8'h5A, 8'h00);
    waitAck("p1 write ram", 0, 2);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0200, 8'h00, 8'h5A);
    waitAck("p1 readback ram", 2, 0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 16'h0010, 8'hFF, 8'h00);
    waitAck("p0 write rom", 0, 0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 16'h0010, 8'h00, 8'h33);
    waitAck("p0 readback rom", 2, 0);
    checkOutput("rom never written", romWriteSeen, 1'b0);
    @(negedge clk);

    $display("[TB] reset during ACCESS");
    p0Req = 1'b1; p0We = 1'b0; p0Addr = 16'h0004;
    @(negedge clk);
    checkOutput("abort pre busy", busy, 1'b1);
    checkOutput("abort pre mem_read", memRead, 1'b1);
    reset_n = 1'b0;
    p0Req = 1'b0;
    @(negedge clk);
    checkOutput("abort strobes", {memRead, memWrite}, 2'b00);
    checkOutput("abort busy", busy, 1'b0);
    checkOutput("abort rdata", {p0Rdata, p1Rdata}, 16'h0000);
    checkOutput("abort owner", owner, 1'b1);
    reset_n = 1'b1;
    heldRdata[0] = 8'h00;
    heldRdata[1] = 8'h00;
    modelLast = 1'b1;
    ackSeen = p0Ack | p1Ack;
    repeat (4) begin
      @(negedge clk);
      ackSeen = ackSeen | p0Ack | p1Ack;
    end
    checkOutput("abort no ack", ackSeen, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0010, 8'h00, 8'h33);
    waitAck("post-reset read", 2, 0);
    @(negedge clk);

    $display("[TB] contention");
    for (int n = 0; n < 4; n++) begin
`ifdef ARB_ROUND_ROBIN_EN
      e.port = ~modelLast;
`else
      e.port = 1'b0;
`endif
      modelLast = e.port;
      heldRdata[e.port] = e.port ? 8'h5A : 8'h0A;
      e.rdata = heldRdata[e.port];
      e.err = 1'b0;
      sbQ.push_back(e);
    end
    p0Req = 1'b1; p0We = 1'b0; p0Addr = 16'h0004;
    p1Req = 1'b1; p1We = 1'b0; p1Addr = 16'h0200;
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (p0Ack || p1Ack) begin
          got = 1'b1;
          break;
        end
      end
      checkOutput("contention ack seen", got, 1'b1);
      if (got) popCompare("contention");
    end
    p0Req = 1'b0;
    p1Req = 1'b0;
    sbQ.delete();
    @(negedge clk);

    $display("[TB] WAIT_STATES=0 back-to-back reads");
    zStrobes = 0;
    zAcks = 0;
    zLastAck = 0;
    zP0Req = 1'b1;
    zP0Addr = 16'h0004;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (zMemRead) zStrobes++;
      if (zP0Ack) begin
        zAcks++;
        checkOutput("ws0 rdata", zP0Rdata, 8'h0A);
        checkOutput("ws0 ack spacing", i - zLastAck, (zAcks == 1) ? 2 : 3);
        checkOutput("ws0 strobes per access", zStrobes, zAcks);
        zLastAck = i;
        if (zAcks == 3) break;
      end
    end
    zP0Req = 1'b0;
    checkOutput("ws0 acks seen", zAcks, 3);
    checkOutput("ws0 p1 never acked", zP1Ack, 1'b0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
